// File: rtl/control_cabina.sv
// Car-side responder: latches hall/cabin requests, times floor travel and door-open
// intervals, and clears requests served while the doors are open.
module control_cabina #(
  parameter int T_PISO   = 50,
  parameter int T_PUERTA = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] estado,
  input  logic [9:0] botones,
  output logic [9:0] s,
  output logic       cambio_piso,
  output logic       esperar
);

  localparam int CMAX = (T_PISO > T_PUERTA) ? T_PISO : T_PUERTA;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {
    REPOSO,
    VIAJANDO,
    PUERTA_ABIERTA
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          cp_n;
  logic [9:0]    mask, clr;
  logic          at_limit;

  function automatic logic [9:0] served_mask(input logic [1:0] floor, input logic up);
    logic [9:0] m;
    m = '0;
    case (floor)
      2'd0: begin
        m[0] = 1'b1;
        m[6] = 1'b1;
      end
      2'd1: begin
        m[7] = 1'b1;
        if (up) m[2] = 1'b1;
        else    m[1] = 1'b1;
      end
      2'd2: begin
        m[8] = 1'b1;
        if (up) m[4] = 1'b1;
        else    m[3] = 1'b1;
      end
      default: begin
        m[5] = 1'b1;
        m[9] = 1'b1;
      end
    endcase
    return m;
  endfunction

  always_comb begin
    mask     = served_mask(estado[1:0], estado[2]);
    clr      = (state == PUERTA_ABIERTA) ? mask : '0;
    // Travelling past the top or bottom floor must never produce a floor change.
    at_limit = (estado[2] && (estado[1:0] == 2'd3)) || (!estado[2] && (estado[1:0] == 2'd0));
    state_n  = state;
    cnt_n    = cnt;
    cp_n     = cambio_piso;
    case (state)
      REPOSO: begin
        if (estado[3]) begin
          state_n = VIAJANDO;
          cnt_n   = '0;
        end else if (((s | botones) & mask) != '0) begin
          state_n = PUERTA_ABIERTA;
          cnt_n   = '0;
        end
      end
      VIAJANDO: begin
        if (!estado[3]) begin
          state_n = PUERTA_ABIERTA;
          cnt_n   = '0;
        end else if (cnt == CW'(T_PISO - 1)) begin
          if (!at_limit) begin
            cp_n  = ~cambio_piso;
            cnt_n = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PUERTA_ABIERTA: begin
        if ((botones & mask) != '0) begin
          cnt_n = '0;
        end else if (cnt == CW'(T_PUERTA - 1)) begin
          state_n = REPOSO;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = REPOSO;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= REPOSO;
      cnt         <= '0;
      s           <= '0;
      cambio_piso <= 1'b0;
      esperar     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      s           <= (s | botones) & ~clr;
      cambio_piso <= cp_n;
      esperar     <= (state_n == PUERTA_ABIERTA);
    end
  end

endmodule
